// File: rtl/exec_unit_mc_if.sv
// Handshake and data bundle between the ID/EX buffer, the execution unit and the memory stage.
// The master drives operations and the consume strobe; the slave (execution unit) drives results.
interface exec_unit_mc_if #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned ADDR_W = 32
);
  logic                  in_valid;
  logic                  in_ready;
  logic [3:0]            op;
  logic [WIDTH-1:0]      a;
  logic [WIDTH-1:0]      b;
  logic                  flag_en;
  logic [2:0]            wb_addr;
  logic                  flush;
  logic                  out_valid;
  logic                  out_ready;
  logic [2*WIDTH-1:0]    result;
  logic [ADDR_W-1:0]     addr;
  logic [2:0]            wb_addr_out;
  logic [2:0]            flags;
  logic [ADDR_W-1:0]     sp;
  logic                  busy;

  modport master (
    output in_valid, op, a, b, flag_en, wb_addr, flush, out_ready,
    input  in_ready, out_valid, result, addr, wb_addr_out, flags, sp, busy
  );

  modport slave (
    input  in_valid, op, a, b, flag_en, wb_addr, flush, out_ready,
    output in_ready, out_valid, result, addr, wb_addr_out, flags, sp, busy
  );
endinterface

// File: rtl/exec_unit_mc.sv
// Pipelined execution unit: single-cycle ALU/stack ops plus iterative shift-add multiply and
// restoring divide, with a registered EX/MEM output stage, flag register and stack pointer.
module exec_unit_mc #(
  parameter int unsigned       WIDTH   = 16,
  parameter int unsigned       ADDR_W  = 32,
  parameter logic [ADDR_W-1:0] SP_INIT = '1
) (
  input logic           clk,
  input logic           rst_n,
  exec_unit_mc_if.slave bus
);
  localparam int unsigned ShW  = $clog2(WIDTH);
  localparam int unsigned CntW = ShW + 1;

  localparam logic [3:0] OpAdd  = 4'd0;
  localparam logic [3:0] OpSub  = 4'd1;
  localparam logic [3:0] OpAnd  = 4'd2;
  localparam logic [3:0] OpOr   = 4'd3;
  localparam logic [3:0] OpShl  = 4'd4;
  localparam logic [3:0] OpShr  = 4'd5;
  localparam logic [3:0] OpMov  = 4'd6;
  localparam logic [3:0] OpNot  = 4'd7;
  localparam logic [3:0] OpMul  = 4'd8;
  localparam logic [3:0] OpDiv  = 4'd9;
  localparam logic [3:0] OpPush = 4'd10;
  localparam logic [3:0] OpPop  = 4'd11;

  typedef enum logic [1:0] {StIdle, StMul, StDiv} state_e;

  state_e              state_q;
  logic [CntW-1:0]     cnt_q;
  logic [2*WIDTH-1:0]  acc_q;        // MUL: {partial product, multiplier}; DIV: {rem, quot}
  logic [WIDTH-1:0]    opnd_q;       // multiplicand or divisor
  logic                pend_fe_q;
  logic [2:0]          pend_wb_q;
  logic [ADDR_W-1:0]   pend_addr_q;
  logic                out_valid_q;
  logic [2*WIDTH-1:0]  result_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [ADDR_W-1:0]   sp_q;
  logic [2:0]          wb_q;
  logic [2:0]          flags_q;

  logic                free, accept, mc_done, div0;
  logic [WIDTH:0]      add_w, sub_w, shl_w;
  logic [ShW-1:0]      sh;
  logic [WIDTH-1:0]    alu_res;
  logic                alu_cf;
  logic [ADDR_W-1:0]   alu_addr, sp_next;
  logic [2*WIDTH-1:0]  sc_res;
  logic [WIDTH:0]      mul_sum, div_sh, div_diff;
  logic [2*WIDTH-1:0]  mul_nxt, div_nxt;
  logic                mc_cf;

  assign free         = !out_valid_q || bus.out_ready;
  assign bus.in_ready = (state_q == StIdle) && free && !bus.flush;
  assign accept       = bus.in_valid && bus.in_ready;
  assign mc_done      = (state_q != StIdle) && (cnt_q == CntW'(WIDTH));
  assign div0         = (bus.op == OpDiv) && (bus.b == '0);

  always_comb begin
    sh       = bus.b[ShW-1:0];
    add_w    = {1'b0, bus.a} + {1'b0, bus.b};
    sub_w    = {1'b0, bus.a} - {1'b0, bus.b};
    shl_w    = {1'b0, bus.a} << sh;  // bit WIDTH holds the last bit shifted out
    alu_res  = '0;
    alu_cf   = flags_q[1];
    alu_addr = ADDR_W'(bus.b);
    sp_next  = sp_q;
    case (bus.op)
      OpAdd:  begin alu_res = add_w[WIDTH-1:0]; alu_cf = add_w[WIDTH]; end
      OpSub:  begin alu_res = sub_w[WIDTH-1:0]; alu_cf = sub_w[WIDTH]; end
      OpAnd:  alu_res = bus.a & bus.b;
      OpOr:   alu_res = bus.a | bus.b;
      OpShl:  begin alu_res = shl_w[WIDTH-1:0]; alu_cf = shl_w[WIDTH]; end
      OpShr:  alu_res = bus.a >> sh;
      OpMov:  alu_res = bus.a;
      OpNot:  alu_res = ~bus.a;
      OpDiv:  alu_cf = 1'b1;
      OpPush: begin alu_res = bus.a; alu_addr = sp_q; sp_next = sp_q - ADDR_W'(1); end
      OpPop:  begin sp_next = sp_q + ADDR_W'(1); alu_addr = sp_q + ADDR_W'(1); end
      default: ;
    endcase
    sc_res = div0 ? {bus.a, {WIDTH{1'b1}}} : {{WIDTH{1'b0}}, alu_res};

    mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    mul_nxt  = {mul_sum, acc_q[WIDTH-1:1]};
    div_sh   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    div_diff = div_sh - {1'b0, opnd_q};
    div_nxt  = div_diff[WIDTH] ? {div_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                               : {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
    mc_cf    = (state_q == StMul) ? |acc_q[2*WIDTH-1:WIDTH] : 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      acc_q       <= '0;
      opnd_q      <= '0;
      pend_fe_q   <= 1'b0;
      pend_wb_q   <= '0;
      pend_addr_q <= '0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      addr_q      <= '0;
      sp_q        <= SP_INIT;
      wb_q        <= '0;
      flags_q     <= '0;
    end else if (bus.flush) begin
      state_q     <= StIdle;
      out_valid_q <= 1'b0;
    end else begin
      if (out_valid_q && bus.out_ready) out_valid_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (accept) begin
            pend_fe_q   <= bus.flag_en;
            pend_wb_q   <= bus.wb_addr;
            pend_addr_q <= alu_addr;
            cnt_q       <= '0;
            if (bus.op == OpMul) begin
              state_q <= StMul;
              acc_q   <= {{WIDTH{1'b0}}, bus.b};
              opnd_q  <= bus.a;
            end else if (bus.op == OpDiv && !div0) begin
              state_q <= StDiv;
              acc_q   <= {{WIDTH{1'b0}}, bus.a};
              opnd_q  <= bus.b;
            end else begin
              out_valid_q <= 1'b1;
              result_q    <= sc_res;
              addr_q      <= alu_addr;
              wb_q        <= bus.wb_addr;
              sp_q        <= sp_next;
              if (bus.flag_en) begin
                flags_q <= {sc_res[WIDTH-1], alu_cf, sc_res[WIDTH-1:0] == '0};
              end
            end
          end
        end
        default: begin
          if (mc_done) begin
            // Result waits in acc_q until the output register can take it.
            if (free) begin
              state_q     <= StIdle;
              out_valid_q <= 1'b1;
              result_q    <= acc_q;
              addr_q      <= pend_addr_q;
              wb_q        <= pend_wb_q;
              if (pend_fe_q) begin
                flags_q <= {acc_q[WIDTH-1], mc_cf, acc_q[WIDTH-1:0] == '0};
              end
            end
          end else begin
            acc_q <= (state_q == StMul) ? mul_nxt : div_nxt;
            cnt_q <= cnt_q + CntW'(1);
          end
        end
      endcase
    end
  end

  assign bus.out_valid   = out_valid_q;
  assign bus.result      = result_q;
  assign bus.addr        = addr_q;
  assign bus.wb_addr_out = wb_q;
  assign bus.flags       = flags_q;
  assign bus.sp          = sp_q;
  assign bus.busy        = (state_q != StIdle);
endmodule

// File: tb/tb_exec_unit_mc.sv
// Directed self-checking bench for exec_unit_mc with hand-computed expectations (WIDTH=16).
module tb_exec_unit_mc;
  localparam int unsigned W  = 16;
  localparam int unsigned AW = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  exec_unit_mc_if #(.WIDTH(W), .ADDR_W(AW)) bus ();

  exec_unit_mc #(.WIDTH(W), .ADDR_W(AW), .SP_INIT(32'hFFFF_FFFF)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic        fe;
    logic [15:0] res;
    logic [2:0]  fl;
  } vec_t;

  vec_t vecs [7];

  task automatic issue(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                       input logic fe, input logic [2:0] wb);
    bus.op = op; bus.a = a; bus.b = b; bus.flag_en = fe; bus.wb_addr = wb;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic test_reset;
    bus.in_valid = 0; bus.op = 0; bus.a = 0; bus.b = 0; bus.flag_en = 0; bus.wb_addr = 0;
    bus.flush = 0; bus.out_ready = 1;
    #12;
    checks++;
    if ({bus.out_valid, bus.busy, bus.result, bus.addr, bus.wb_addr_out, bus.flags, bus.sp}
        !== {1'b0, 1'b0, 32'h0, 32'h0, 3'h0, 3'h0, 32'hFFFF_FFFF}) begin
      failures++;
      $display("FAIL reset_state got ov=%b busy=%b res=%h addr=%h wb=%h fl=%b sp=%h want zeros sp=ffffffff",
               bus.out_valid, bus.busy, bus.result, bus.addr, bus.wb_addr_out, bus.flags, bus.sp);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_in_ready got %b want 1", bus.in_ready);
    end
  endtask

  task automatic test_stack;
    issue(4'd10, 16'hABCD, 16'h0, 1'b0, 3'd1);
    checks++;
    if ({bus.out_valid, bus.result, bus.addr, bus.sp}
        !== {1'b1, 32'h0000_ABCD, 32'hFFFF_FFFF, 32'hFFFF_FFFE}) begin
      failures++;
      $display("FAIL push got ov=%b res=%h addr=%h sp=%h want 1 0000abcd ffffffff fffffffe",
               bus.out_valid, bus.result, bus.addr, bus.sp);
    end
    issue(4'd11, 16'h0, 16'h0, 1'b0, 3'd2);
    checks++;
    if ({bus.out_valid, bus.addr, bus.sp} !== {1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF}) begin
      failures++;
      $display("FAIL pop1 got ov=%b addr=%h sp=%h want 1 ffffffff ffffffff",
               bus.out_valid, bus.addr, bus.sp);
    end
    issue(4'd11, 16'h0, 16'h0, 1'b0, 3'd2);
    checks++;
    if ({bus.addr, bus.sp} !== {32'h0, 32'h0}) begin
      failures++;
      $display("FAIL pop_wrap got addr=%h sp=%h want 00000000 00000000", bus.addr, bus.sp);
    end
  endtask

  task automatic test_add;
    issue(4'd0, 16'hFFFF, 16'h0001, 1'b1, 3'd3);
    checks++;
    if ({bus.out_valid, bus.result, bus.flags, bus.wb_addr_out, bus.addr}
        !== {1'b1, 32'h0, 3'b011, 3'd3, 32'h1}) begin
      failures++;
      $display("FAIL add_carry got ov=%b res=%h fl=%b wb=%0d addr=%h want 1 00000000 011 3 00000001",
               bus.out_valid, bus.result, bus.flags, bus.wb_addr_out, bus.addr);
    end
    @(posedge clk); #1;
    checks++;
    if (bus.out_valid !== 1'b0) begin
      failures++;
      $display("FAIL add_consumed got ov=%b want 0", bus.out_valid);
    end
  endtask

  task automatic test_back_to_back;
    vecs[0] = '{4'd4, 16'h8001, 16'h0001, 1'b1, 16'h0002, 3'b010};
    vecs[1] = '{4'd5, 16'h8000, 16'h000F, 1'b1, 16'h0001, 3'b010};
    vecs[2] = '{4'd2, 16'hF0F0, 16'h0F0F, 1'b1, 16'h0000, 3'b011};
    vecs[3] = '{4'd3, 16'h8000, 16'h0001, 1'b1, 16'h8001, 3'b110};
    vecs[4] = '{4'd7, 16'h00FF, 16'h0000, 1'b1, 16'hFF00, 3'b110};
    vecs[5] = '{4'd4, 16'h8001, 16'h0010, 1'b1, 16'h8001, 3'b100};
    vecs[6] = '{4'd0, 16'h0001, 16'h0001, 1'b0, 16'h0002, 3'b100};
    for (int i = 0; i < 7; i++) begin
      bus.op = vecs[i].op; bus.a = vecs[i].a; bus.b = vecs[i].b;
      bus.flag_en = vecs[i].fe; bus.wb_addr = 3'(i); bus.in_valid = 1'b1;
      @(posedge clk); #1;
      checks++;
      if ({bus.out_valid, bus.result, bus.flags, bus.wb_addr_out, bus.addr}
          !== {1'b1, 16'h0, vecs[i].res, vecs[i].fl, 3'(i), 16'h0, vecs[i].b}) begin
        failures++;
        $display("FAIL b2b[%0d] got ov=%b res=%h fl=%b wb=%0d addr=%h want res=%h fl=%b",
                 i, bus.out_valid, bus.result, bus.flags, bus.wb_addr_out, bus.addr,
                 vecs[i].res, vecs[i].fl);
      end
    end
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure;
    bus.out_ready = 1'b0;
    issue(4'd1, 16'd3, 16'd5, 1'b1, 3'd4);
    bus.op = 4'd0; bus.a = 16'd1; bus.b = 16'd1; bus.flag_en = 1'b1; bus.in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({bus.out_valid, bus.result, bus.flags, bus.in_ready}
          !== {1'b1, 32'h0000_FFFE, 3'b110, 1'b0}) begin
        failures++;
        $display("FAIL stall[%0d] got ov=%b res=%h fl=%b rdy=%b want 1 0000fffe 110 0",
                 i, bus.out_valid, bus.result, bus.flags, bus.in_ready);
      end
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL stall_release_ready got %b want 1", bus.in_ready);
    end
    @(posedge clk); #1;
    checks++;
    if ({bus.out_valid, bus.flags} !== {1'b0, 3'b110}) begin
      failures++;
      $display("FAIL stall_consumed got ov=%b fl=%b want 0 110", bus.out_valid, bus.flags);
    end
  endtask

  task automatic test_mul;
    int bad;
    bad = 0;
    issue(4'd8, 16'h1234, 16'h0010, 1'b1, 3'd5);
    for (int i = 0; i < 17; i++) begin
      if (!(bus.busy === 1'b1 && bus.in_ready === 1'b0 && bus.out_valid === 1'b0)) bad++;
      @(posedge clk); #1;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL mul_busy got %0d bad cycles want 0", bad);
    end
    checks++;
    if ({bus.out_valid, bus.busy, bus.result, bus.flags, bus.wb_addr_out}
        !== {1'b1, 1'b0, 32'h0001_2340, 3'b010, 3'd5}) begin
      failures++;
      $display("FAIL mul_result got ov=%b busy=%b res=%h fl=%b wb=%0d want 1 0 00012340 010 5",
               bus.out_valid, bus.busy, bus.result, bus.flags, bus.wb_addr_out);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_div;
    int n;
    n = 0;
    issue(4'd9, 16'd100, 16'd7, 1'b1, 3'd6);
    while (!bus.out_valid && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if ({bus.out_valid, bus.result, bus.flags} !== {1'b1, 32'h0002_000E, 3'b000} || n != 17) begin
      failures++;
      $display("FAIL div_result got ov=%b res=%h fl=%b edges=%0d want 1 0002000e 000 17",
               bus.out_valid, bus.result, bus.flags, n);
    end
    issue(4'd9, 16'd5, 16'd0, 1'b1, 3'd7);
    checks++;
    if ({bus.out_valid, bus.busy, bus.result, bus.flags}
        !== {1'b1, 1'b0, 32'h0005_FFFF, 3'b110}) begin
      failures++;
      $display("FAIL div_zero got ov=%b busy=%b res=%h fl=%b want 1 0 0005ffff 110",
               bus.out_valid, bus.busy, bus.result, bus.flags);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_flush;
    issue(4'd8, 16'd3, 16'd0, 1'b1, 3'd1);
    repeat (4) begin @(posedge clk); #1; end
    bus.flush = 1'b1;
    bus.op = 4'd0; bus.a = 16'd2; bus.b = 16'd2; bus.flag_en = 1'b1; bus.in_valid = 1'b1;
    #1;
    checks++;
    if (bus.in_ready !== 1'b0) begin
      failures++;
      $display("FAIL flush_blocks_accept got rdy=%b want 0", bus.in_ready);
    end
    @(posedge clk); #1;
    bus.flush = 1'b0;
    bus.in_valid = 1'b0;
    #1;
    checks++;
    if ({bus.out_valid, bus.busy, bus.flags, bus.sp, bus.in_ready}
        !== {1'b0, 1'b0, 3'b110, 32'h0, 1'b1}) begin
      failures++;
      $display("FAIL flush_state got ov=%b busy=%b fl=%b sp=%h rdy=%b want 0 0 110 00000000 1",
               bus.out_valid, bus.busy, bus.flags, bus.sp, bus.in_ready);
    end
    repeat (20) begin @(posedge clk); #1; end
    checks++;
    if ({bus.out_valid, bus.flags} !== {1'b0, 3'b110}) begin
      failures++;
      $display("FAIL flush_no_trace got ov=%b fl=%b want 0 110", bus.out_valid, bus.flags);
    end
  endtask

  task automatic test_reset_mid_div;
    issue(4'd9, 16'd100, 16'd7, 1'b1, 3'd2);
    repeat (5) begin @(posedge clk); #1; end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.out_valid, bus.busy, bus.result, bus.addr, bus.wb_addr_out, bus.flags, bus.sp}
        !== {1'b0, 1'b0, 32'h0, 32'h0, 3'h0, 3'h0, 32'hFFFF_FFFF}) begin
      failures++;
      $display("FAIL reset_mid_div got ov=%b busy=%b res=%h addr=%h wb=%h fl=%b sp=%h",
               bus.out_valid, bus.busy, bus.result, bus.addr, bus.wb_addr_out, bus.flags, bus.sp);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (20) begin @(posedge clk); #1; end
    checks++;
    if ({bus.out_valid, bus.busy, bus.in_ready} !== {1'b0, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL reset_no_trace got ov=%b busy=%b rdy=%b want 0 0 1",
               bus.out_valid, bus.busy, bus.in_ready);
    end
  endtask

  initial begin
    test_reset();
    test_stack();
    test_add();
    test_back_to_back();
    test_backpressure();
    test_mul();
    test_div();
    test_flush();
    test_reset_mid_div();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
